// File: rtl/pipeline_pkg.sv
// pipeline_pkg: operand-select and branch FSM encodings shared by the hazard unit and its users.
package pipeline_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BR_E = 2'd1, BR_M = 2'd2, BR_W = 2'd3} br_state_e;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;
endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// pipeline_hazard_unit_if: decode-stage instruction info in, pipeline hold/bubble/forward controls out.
interface pipeline_hazard_unit_if #(
  parameter int NUM_RD_PORTS = 2,
  parameter int REG_AW       = 4,
  parameter int CNT_W        = 16
);
  logic                           ISSUE_VALID_D;
  logic [NUM_RD_PORTS*REG_AW-1:0] RA_D;
  logic [NUM_RD_PORTS-1:0]        RA_USED_D;
  logic [REG_AW-1:0]              WA_D;
  logic                           REG_WRITE_D;
  logic                           MEM_TO_REG_D;
  logic                           PC_WRITE_D;
  logic                           STALL_F;
  logic                           STALL_D;
  logic                           FLUSH_D;
  logic                           FLUSH_E;
  logic [2*NUM_RD_PORTS-1:0]      FWD_SEL_E;
  logic                           BUSY;
  logic [CNT_W-1:0]               STALL_CNT;
  logic [CNT_W-1:0]               FLUSH_CNT;
  modport master (
    output ISSUE_VALID_D, RA_D, RA_USED_D, WA_D, REG_WRITE_D, MEM_TO_REG_D, PC_WRITE_D,
    input  STALL_F, STALL_D, FLUSH_D, FLUSH_E, FWD_SEL_E, BUSY, STALL_CNT, FLUSH_CNT
  );
  modport slave (
    input  ISSUE_VALID_D, RA_D, RA_USED_D, WA_D, REG_WRITE_D, MEM_TO_REG_D, PC_WRITE_D,
    output STALL_F, STALL_D, FLUSH_D, FLUSH_E, FWD_SEL_E, BUSY, STALL_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/pipeline_hazard_unit_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = (inc && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: E/M/W scoreboard driving operand forwarding, load-use stalls
// and a branch FSM that holds fetch until the redirected PC is written back.
module pipeline_hazard_unit
  import pipeline_pkg::*;
#(
  parameter int NUM_RD_PORTS = 2,
  parameter int REG_AW       = 4,
  parameter int PC_REG       = 15,
  parameter int CNT_W        = 16
) (
  input logic                    CLK,
  input logic                    RESET,
  pipeline_hazard_unit_if.slave  hz
);
  localparam logic [REG_AW-1:0] PC_A = REG_AW'(PC_REG);
  typedef struct packed {
    logic                           valid;
    logic [REG_AW-1:0]              dest;
    logic                           rw;
    logic                           ld;
    logic [NUM_RD_PORTS*REG_AW-1:0] src;
    logic [NUM_RD_PORTS-1:0]        used;
  } e_ent_t;
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              rw;
  } wb_ent_t;
  e_ent_t                    e_q, e_d;
  wb_ent_t                   m_q, w_q;
  br_state_e                 state_q, state_d;
  logic                      hit, load_use, br_start, pc_pending, flush_e_br, flush_e, flush_d, stall_f;
  logic [2*NUM_RD_PORTS-1:0] fwd;
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      hit = hit | (hz.RA_USED_D[p] && hz.RA_D[p*REG_AW +: REG_AW] == e_q.dest);
      fwd[2*p +: 2] =
        (e_q.used[p] && e_q.src[p*REG_AW +: REG_AW] != PC_A && m_q.valid && m_q.rw &&
         m_q.dest == e_q.src[p*REG_AW +: REG_AW]) ? FWD_M :
        (e_q.used[p] && e_q.src[p*REG_AW +: REG_AW] != PC_A && w_q.valid && w_q.rw &&
         w_q.dest == e_q.src[p*REG_AW +: REG_AW]) ? FWD_W : FWD_RF;
    end
  end
  assign load_use   = hz.ISSUE_VALID_D && e_q.valid && e_q.ld && e_q.rw && hit;
  assign br_start   = state_q == IDLE && hz.ISSUE_VALID_D && hz.PC_WRITE_D && !load_use;
  assign pc_pending = br_start || state_q == BR_E || state_q == BR_M;
  // Branches resolve in W, so the branch itself is never squashed out of E.
  assign flush_e_br = 1'b0;
  assign flush_e    = load_use || flush_e_br;
  assign flush_d    = pc_pending || state_q == BR_W;
  assign stall_f    = pc_pending || load_use;
  always_comb begin
    state_d = state_q == IDLE ? (br_start ? BR_E : IDLE) :
              state_q == BR_E ? BR_M :
              state_q == BR_M ? BR_W : IDLE;
    e_d = flush_e ? '0 : '{valid: hz.ISSUE_VALID_D, dest: hz.WA_D, rw: hz.REG_WRITE_D,
                           ld: hz.MEM_TO_REG_D, src: hz.RA_D, used: hz.RA_USED_D};
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      m_q     <= '{valid: e_q.valid, dest: e_q.dest, rw: e_q.rw};
      w_q     <= m_q;
    end
  end
  assign hz.STALL_F   = RESET && stall_f;
  assign hz.STALL_D   = RESET && load_use;
  assign hz.FLUSH_D   = RESET && flush_d;
  assign hz.FLUSH_E   = RESET && flush_e;
  assign hz.FWD_SEL_E = RESET ? fwd : '0;
  assign hz.BUSY      = RESET && state_q != IDLE;
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.CLK(CLK), .RESET(RESET), .inc(load_use), .cnt(hz.STALL_CNT));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.CLK(CLK), .RESET(RESET), .inc(flush_d), .cnt(hz.FLUSH_CNT));
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: directed instruction sequences against a default unit and a 2-bit-counter unit.
module tb_pipeline_hazard_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv, rw, ld, pw;
  logic [7:0] ra;
  logic [1:0] used;
  logic [3:0] wa;
  int         total = 0;
  int         bad = 0;
  pipeline_hazard_unit_if                hif ();
  pipeline_hazard_unit_if #(.CNT_W(2))   hif2 ();
  assign hif.ISSUE_VALID_D  = iv;
  assign hif.RA_D           = ra;
  assign hif.RA_USED_D      = used;
  assign hif.WA_D           = wa;
  assign hif.REG_WRITE_D    = rw;
  assign hif.MEM_TO_REG_D   = ld;
  assign hif.PC_WRITE_D     = pw;
  assign hif2.ISSUE_VALID_D = iv;
  assign hif2.RA_D          = ra;
  assign hif2.RA_USED_D     = used;
  assign hif2.WA_D          = wa;
  assign hif2.REG_WRITE_D   = rw;
  assign hif2.MEM_TO_REG_D  = ld;
  assign hif2.PC_WRITE_D    = pw;
  pipeline_hazard_unit u_dut (.CLK(clk), .RESET(rst_n), .hz(hif.slave));
  pipeline_hazard_unit #(.CNT_W(2)) u_sat (.CLK(clk), .RESET(rst_n), .hz(hif2.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [3:0] a0, input logic [3:0] a1, input logic [1:0] u,
                       input logic [3:0] w, input logic r, input logic l, input logic p);
    iv = v; ra = {a1, a0}; used = u; wa = w; rw = r; ld = l; pw = p;
    #2;
  endtask
  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
  endtask
  task automatic branch_seq(input string tag);
    for (int i = 1; i <= 4; i++) begin
      tick();
      idle();
      chk({tag, "_stall_f"}, 32'(hif.STALL_F), 32'(i < 3));
      chk({tag, "_flush_d"}, 32'(hif.FLUSH_D), 32'(i < 4));
      chk({tag, "_busy"},    32'(hif.BUSY),    32'(i < 4));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    drive(1'b1, 4'd1, 4'd2, 2'b11, 4'd3, 1'b1, 1'b0, 1'b1);
    chk("rst_stall_f", 32'(hif.STALL_F), 0);
    chk("rst_flush_d", 32'(hif.FLUSH_D), 0);
    chk("rst_busy", 32'(hif.BUSY), 0);
    chk("rst_fwd", 32'(hif.FWD_SEL_E), 0);
    chk("rst_stall_cnt", 32'(hif.STALL_CNT), 0);
    tick();
    rst_n = 1'b1;
    idle();
    // ALU-to-ALU: ADD R1,R2,R3 then SUB R2,R1,R3
    tick(); drive(1'b1, 4'd2, 4'd3, 2'b11, 4'd1, 1'b1, 1'b0, 1'b0);
    chk("alu_stall_f0", 32'(hif.STALL_F), 0);
    tick(); drive(1'b1, 4'd1, 4'd3, 2'b11, 4'd2, 1'b1, 1'b0, 1'b0);
    chk("alu_stall_f1", 32'(hif.STALL_F), 0);
    chk("alu_stall_d1", 32'(hif.STALL_D), 0);
    tick(); idle();
    chk("alu_fwd_m", 32'(hif.FWD_SEL_E), 32'h2);
    tick();
    chk("alu_fwd_after", 32'(hif.FWD_SEL_E), 0);
    // load-use: LDR R4,[R0] then ADD R5,R4,R4
    tick(); drive(1'b1, 4'd0, 4'd0, 2'b01, 4'd4, 1'b1, 1'b1, 1'b0);
    chk("lu_ldr_stall_f", 32'(hif.STALL_F), 0);
    tick(); drive(1'b1, 4'd4, 4'd4, 2'b11, 4'd5, 1'b1, 1'b0, 1'b0);
    chk("lu_stall_f", 32'(hif.STALL_F), 1);
    chk("lu_stall_d", 32'(hif.STALL_D), 1);
    chk("lu_flush_e", 32'(hif.FLUSH_E), 1);
    chk("lu_flush_d", 32'(hif.FLUSH_D), 0);
    tick();
    chk("lu_retry_stall_f", 32'(hif.STALL_F), 0);
    chk("lu_retry_stall_d", 32'(hif.STALL_D), 0);
    chk("lu_retry_flush_e", 32'(hif.FLUSH_E), 0);
    tick(); idle();
    chk("lu_fwd_w", 32'(hif.FWD_SEL_E), 32'h5);
    chk("lu_stall_cnt", 32'(hif.STALL_CNT), 1);
    chk("lu_flush_cnt", 32'(hif.FLUSH_CNT), 0);
    // branch from IDLE
    tick(); drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("br_stall_f", 32'(hif.STALL_F), 1);
    chk("br_flush_d", 32'(hif.FLUSH_D), 1);
    chk("br_busy", 32'(hif.BUSY), 0);
    chk("br_stall_d", 32'(hif.STALL_D), 0);
    branch_seq("br");
    chk("br_flush_cnt", 32'(hif.FLUSH_CNT), 4);
    // PC source never forwarded, M over W priority, W-only forward
    tick(); drive(1'b1, 4'd0, 4'd0, 2'b01, 4'd15, 1'b1, 1'b0, 1'b0);
    tick(); drive(1'b1, 4'd15, 4'd15, 2'b11, 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    chk("pc_fwd", 32'(hif.FWD_SEL_E), 0);
    tick(); drive(1'b1, 4'd0, 4'd0, 2'b01, 4'd6, 1'b1, 1'b0, 1'b0);
    tick();
    tick(); drive(1'b1, 4'd0, 4'd6, 2'b10, 4'd8, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    chk("prio_fwd_m", 32'(hif.FWD_SEL_E), 32'h8);
    tick(); drive(1'b1, 4'd0, 4'd0, 2'b01, 4'd7, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    tick(); drive(1'b1, 4'd7, 4'd0, 2'b01, 4'd8, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    chk("w_only_fwd", 32'(hif.FWD_SEL_E), 32'h1);
    // coincident load-use and branch: LDR R2 then BX R2
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 2'b01, 4'd2, 1'b1, 1'b1, 1'b0);
    tick(); drive(1'b1, 4'd2, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("bx_lu_stall_f", 32'(hif.STALL_F), 1);
    chk("bx_lu_stall_d", 32'(hif.STALL_D), 1);
    chk("bx_lu_flush_e", 32'(hif.FLUSH_E), 1);
    chk("bx_lu_flush_d", 32'(hif.FLUSH_D), 0);
    chk("bx_lu_busy", 32'(hif.BUSY), 0);
    tick();
    chk("bx_go_stall_f", 32'(hif.STALL_F), 1);
    chk("bx_go_stall_d", 32'(hif.STALL_D), 0);
    chk("bx_go_flush_d", 32'(hif.FLUSH_D), 1);
    chk("bx_go_busy", 32'(hif.BUSY), 0);
    branch_seq("bx");
    chk("bx_stall_cnt", 32'(hif.STALL_CNT), 1);
    chk("bx_flush_cnt", 32'(hif.FLUSH_CNT), 4);
    // repeated LDR R4,[R4] stalls every other cycle: 5 stalls in 10 cycles
    do_reset();
    drive(1'b1, 4'd4, 4'd0, 2'b01, 4'd4, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("sat_stall_d", 32'(hif.STALL_D), 32'(i % 2));
      tick();
    end
    idle();
    chk("sat_cnt16", 32'(hif.STALL_CNT), 5);
    chk("sat_cnt2", 32'(hif2.STALL_CNT), 3);
    // reset asserted while in BR_M
    drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
    tick(); idle();
    tick();
    chk("brm_busy", 32'(hif.BUSY), 1);
    chk("brm_flush_cnt2", 32'(hif2.FLUSH_CNT), 2);
    iv = 1'b1; pw = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("brm_rst_busy", 32'(hif.BUSY), 0);
    chk("brm_rst_stall_f", 32'(hif.STALL_F), 0);
    chk("brm_rst_flush_d", 32'(hif.FLUSH_D), 0);
    chk("brm_rst_stall_cnt", 32'(hif.STALL_CNT), 0);
    chk("brm_rst_flush_cnt", 32'(hif.FLUSH_CNT), 0);
    chk("brm_rst_cnt2", 32'(hif2.STALL_CNT), 0);
    tick();
    iv = 1'b0; pw = 1'b0;
    rst_n = 1'b1;
    idle();
    chk("post_rst_flush_d", 32'(hif.FLUSH_D), 0);
    chk("post_rst_busy", 32'(hif.BUSY), 0);
    tick();
    chk("post_rst_stall_f", 32'(hif.STALL_F), 0);
    chk("post_rst_flush_d2", 32'(hif.FLUSH_D), 0);
    chk("post_rst_flush_cnt", 32'(hif.FLUSH_CNT), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
